// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: request/response
// structs, the XLEN constant, default parameters and the byte-merge helper.
package dmem_pkg;

  localparam int XLEN                = 32;
  localparam int BE_W                = XLEN / 8;
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int DEFAULT_QDEPTH      = 4;
  localparam int MAX_LATENCY         = 8;

  typedef enum logic {
    DMEM_LOAD  = 1'b0,
    DMEM_STORE = 1'b1
  } dmem_op_e;

  typedef struct packed {
    dmem_op_e            op;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic [BE_W-1:0]     be;
  } dmem_req_t;

  typedef struct packed {
    logic [XLEN-1:0]     rdata;
    logic                we;
    logic                err;
  } dmem_rsp_t;

  // Replaces only the byte lanes selected by be; an all-zero be returns oldWord.
  function automatic logic [XLEN-1:0] dmem_merge(
    input logic [XLEN-1:0] oldWord,
    input logic [XLEN-1:0] newWord,
    input logic [BE_W-1:0] be
  );
    logic [XLEN-1:0] merged;
    merged = oldWord;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = newWord[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// LSU-side request/response bundle; master is the LSU, slave is the responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [XLEN-1:0]     req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic [BE_W-1:0]     req_be;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_rdata;
  logic                rsp_we;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

endinterface

// File: rtl/dmem_rsp_fifo.sv
// In-order response queue between the latency pipeline and the LSU.
// Head entry is presented combinationally and stays put until popped.
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QDEPTH
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      i_push,
  input  dmem_rsp_t i_data,
  input  logic      i_pop,
  output dmem_rsp_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  dmem_rsp_t        r_slots [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_slots[r_rdPtr];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_slots[r_wrPtr] <= i_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled word array with fixed-latency, in-order
// responses. Define DMEM_ERR_CHECK_EN to fault misaligned/out-of-range requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int QDEPTH      = DEFAULT_QDEPTH
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [BE_W-1:0] req_be_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_we_o,
  output logic            rsp_err_o
);

  localparam int IW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int WAW = XLEN - 2;

  dmem_req_t        w_req;
  dmem_rsp_t        w_newRsp;
  dmem_rsp_t        w_head;
  logic             w_accept;
  logic             w_rspHs;
  logic             w_err;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic             w_unused;
  logic [WAW-1:0]   w_wordAddr;
  logic [IW-1:0]    w_idx;

  logic             r_active;
  logic [CW-1:0]    r_outstanding;
  logic [XLEN-1:0]  r_mem [DEPTH_WORDS];
  logic             r_pipeValid [LATENCY];
  dmem_rsp_t        r_pipeData [LATENCY];

  always_comb begin
    w_req = '{op: dmem_op_e'(req_we_i), addr: req_addr_i,
              wdata: req_wdata_i, be: req_be_i};
  end

  assign w_wordAddr = w_req.addr[XLEN-1:2];
  assign w_idx      = IW'(w_wordAddr % WAW'(DEPTH_WORDS));
  assign w_accept   = req_valid_i && req_ready_o;
  assign w_rspHs    = rsp_valid_o && rsp_ready_i;

`ifdef DMEM_ERR_CHECK_EN
  assign w_err    = (w_req.addr[1:0] != 2'b00) || (w_wordAddr >= WAW'(DEPTH_WORDS));
  assign w_unused = &{1'b0, w_fifoFull};
`else
  assign w_err    = 1'b0;
  assign w_unused = &{1'b0, w_fifoFull, w_req.addr[1:0]};
`endif

  // Stores commit on the accept edge, so a later load always sees them.
  always_ff @(posedge clk_i) begin
    if (w_accept && (w_req.op == DMEM_STORE) && !w_err) begin
      r_mem[w_idx] <= dmem_merge(r_mem[w_idx], w_req.wdata, w_req.be);
    end
  end

  always_comb begin
    w_newRsp     = '0;
    w_newRsp.we  = (w_req.op == DMEM_STORE);
    w_newRsp.err = w_err;
    if ((w_req.op == DMEM_LOAD) && !w_err) begin
      w_newRsp.rdata = r_mem[w_idx];
    end
  end

  // Outstanding covers both pipeline and FIFO, so the FIFO can never overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_active      <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_active <= 1'b1;
      case ({w_accept, w_rspHs})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign req_ready_o = r_active && (r_outstanding < CW'(QDEPTH));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_pipeValid[s] <= 1'b0;
        r_pipeData[s]  <= '0;
      end
    end else begin
      r_pipeValid[0] <= w_accept;
      r_pipeData[0]  <= w_newRsp;
      for (int s = 1; s < LATENCY; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeData[s]  <= r_pipeData[s-1];
      end
    end
  end

  dmem_rsp_fifo #(
    .DEPTH (QDEPTH)
  ) u_rspFifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_push  (r_pipeValid[LATENCY-1]),
    .i_data  (r_pipeData[LATENCY-1]),
    .i_pop   (w_rspHs),
    .o_data  (w_head),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Gating keeps the outputs at zero whenever nothing is being presented.
  assign rsp_valid_o = !w_fifoEmpty;
  assign rsp_rdata_o = rsp_valid_o ? w_head.rdata : '0;
  assign rsp_we_o    = rsp_valid_o && w_head.we;
  assign rsp_err_o   = rsp_valid_o && w_head.err;

endmodule
